// File: rtl/ecdsa_avalon_slave_pkg.sv
// Shared definitions for the ECDSA Avalon-MM front-end.
// Register addresses, STATUS/CTRL bit indices and the slave FSM state type.
package elliptic_curve_structs;

    localparam int REG_KEY0   = 0;
    localparam int REG_MSG0   = 8;
    localparam int REG_CTRL   = 11;
    localparam int REG_STATUS = 12;
    localparam int REG_CYCLES = 13;
    localparam int REG_ID     = 14;

    localparam int NUM_KEY_WORDS = 8;
    localparam int NUM_MSG_WORDS = 3;
    localparam int NUM_WORDS     = NUM_KEY_WORDS + NUM_MSG_WORDS;

    localparam int ST_DONE    = 0;
    localparam int ST_INVALID = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_TIMEOUT = 3;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } slave_state_t;

endpackage

// File: rtl/ecdsa_avalon_slave_if.sv
// Avalon-MM bus bundle between the NIOS host and the ECDSA slave.
// master: drives select/strobes/address/data; slave: drives readdata.
interface ecdsa_avalon_slave_if;

    logic        avl_chipselect;
    logic        avl_read;
    logic        avl_write;
    logic [3:0]  avl_address;
    logic [3:0]  avl_byteenable;
    logic [31:0] avl_writedata;
    logic [31:0] avl_readdata;

    modport master (
        output avl_chipselect,
        output avl_read,
        output avl_write,
        output avl_address,
        output avl_byteenable,
        output avl_writedata,
        input  avl_readdata
    );

    modport slave (
        input  avl_chipselect,
        input  avl_read,
        input  avl_write,
        input  avl_address,
        input  avl_byteenable,
        input  avl_writedata,
        output avl_readdata
    );

endinterface

// File: rtl/ecdsa_avalon_slave_avl_word_reg.sv
// 32-bit operand word with per-byte write enable and a write lock.
// Ports: clk, reset (sync, active-low), wr_en, lock, byteenable, wdata, q.
module avl_word_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        lock,
    input  logic [3:0]  byteenable,
    input  logic [31:0] wdata,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (wr_en && !lock) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    q[b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ecdsa_avalon_slave.sv
// Avalon-MM slave front-end for the ECDSA core: operand load, start, status.
// Ports: clk, reset (sync, active-low), avl (bus slave), core_* (core side).
module ecdsa_avalon_slave
    import elliptic_curve_structs::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h0FFF_FFFF,
    parameter logic [31:0] CORE_ID        = 32'hEC25_6001
) (
    input  logic                 clk,
    input  logic                 reset,
    ecdsa_avalon_slave_if.slave  avl,
    output logic [255:0]         core_priv_key,
    output logic [95:0]          core_message,
    output logic                 core_start,
    input  logic                 core_done,
    input  logic                 core_invalid
);

    slave_state_t state;
    slave_state_t state_nxt;

    logic [31:0] words [NUM_WORDS];
    logic [31:0] cnt;
    logic [31:0] cnt_inc;
    logic [31:0] status;
    logic        st_done;
    logic        st_invalid;
    logic        st_timeout;
    logic        busy;
    logic        wr;
    logic        ctrl_wr;
    logic        start_wr;
    logic        clear_wr;
    logic        timeout_hit;
    logic        run_entry;

    assign wr       = avl.avl_chipselect && avl.avl_write;
    assign ctrl_wr  = wr && (avl.avl_address == 4'(REG_CTRL))
                      && avl.avl_byteenable[0];
    assign start_wr = ctrl_wr && avl.avl_writedata[CTRL_START];
    assign clear_wr = ctrl_wr && avl.avl_writedata[CTRL_CLEAR];

    // Operands are locked while the core is running.
    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
        avl_word_reg u_reg (
            .clk        (clk),
            .reset      (reset),
            .wr_en      (wr && (avl.avl_address == 4'(REG_KEY0 + i))),
            .lock       (busy),
            .byteenable (avl.avl_byteenable),
            .wdata      (avl.avl_writedata),
            .q          (words[i])
        );
    end

    for (genvar i = 0; i < NUM_KEY_WORDS; i++) begin : g_key
        assign core_priv_key[i*32 +: 32] = words[REG_KEY0 + i];
    end

    for (genvar i = 0; i < NUM_MSG_WORDS; i++) begin : g_msg
        assign core_message[i*32 +: 32] = words[REG_MSG0 + i];
    end

    assign cnt_inc = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    // Compare the post-increment count so a zero limit still aborts after one cycle.
    assign timeout_hit = (cnt_inc >= TIMEOUT_CYCLES);
    assign run_entry   = (state != RUN) && (state_nxt == RUN);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_wr && !clear_wr) state_nxt = RUN;
            end
            RUN: begin
                if (core_done || timeout_hit) state_nxt = DONE;
            end
            DONE: begin
                if (clear_wr)      state_nxt = IDLE;
                else if (start_wr) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        core_start = (state == RUN);
        busy       = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= '0;
            st_done    <= 1'b0;
            st_invalid <= 1'b0;
            st_timeout <= 1'b0;
        end else if (run_entry) begin
            cnt        <= '0;
            st_done    <= 1'b0;
            st_invalid <= 1'b0;
            st_timeout <= 1'b0;
        end else if (state == RUN) begin
            cnt <= cnt_inc;
            // A real completion beats a coincident timeout.
            if (core_done) begin
                st_done    <= 1'b1;
                st_invalid <= core_invalid;
            end else if (timeout_hit) begin
                st_done    <= 1'b1;
                st_invalid <= 1'b0;
                st_timeout <= 1'b1;
            end
        end else if (clear_wr) begin
            st_done    <= 1'b0;
            st_invalid <= 1'b0;
            st_timeout <= 1'b0;
        end
    end

    always_comb begin
        status             = '0;
        status[ST_DONE]    = st_done;
        status[ST_INVALID] = st_invalid;
        status[ST_BUSY]    = busy;
        status[ST_TIMEOUT] = st_timeout;
    end

    always_comb begin
        avl.avl_readdata = '0;
        if (avl.avl_chipselect && avl.avl_read) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (avl.avl_address == 4'(REG_KEY0 + i)) begin
                    avl.avl_readdata = words[i];
                end
            end
            if (avl.avl_address == 4'(REG_STATUS)) avl.avl_readdata = status;
            if (avl.avl_address == 4'(REG_CYCLES)) avl.avl_readdata = cnt;
            if (avl.avl_address == 4'(REG_ID))     avl.avl_readdata = CORE_ID;
        end
    end

endmodule

// File: tb/tb_ecdsa_avalon_slave.sv
// Directed self-checking bench for ecdsa_avalon_slave.
// Two instances share the bus: default timeout, and a 16-cycle timeout.
module tb_ecdsa_avalon_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [3:0]  be = 4'h0;
    logic [31:0] wdata = 32'h0;

    logic        done_force = 1'b0;
    logic        model_en = 1'b0;
    logic        core_invalid = 1'b0;
    int          done_after = 50;
    int          mcnt = 0;

    logic         core_done;
    logic         cstart;
    logic         cstart_to;
    logic [255:0] key0, key1;
    logic [95:0]  msg0, msg1;

    int passed = 0;
    int total = 0;

    ecdsa_avalon_slave_if bus0 ();
    ecdsa_avalon_slave_if bus1 ();

    assign bus0.avl_chipselect = cs;
    assign bus0.avl_read       = rd;
    assign bus0.avl_write      = wr;
    assign bus0.avl_address    = addr;
    assign bus0.avl_byteenable = be;
    assign bus0.avl_writedata  = wdata;
    assign bus1.avl_chipselect = cs;
    assign bus1.avl_read       = rd;
    assign bus1.avl_write      = wr;
    assign bus1.avl_address    = addr;
    assign bus1.avl_byteenable = be;
    assign bus1.avl_writedata  = wdata;

    // Core model: done for one cycle once start has been high done_after cycles.
    always @(posedge clk) mcnt <= cstart ? mcnt + 1 : 0;
    assign core_done = done_force
                       | (model_en & cstart & (mcnt == done_after - 1));

    ecdsa_avalon_slave dut (
        .clk           (clk),
        .reset         (reset),
        .avl           (bus0),
        .core_priv_key (key0),
        .core_message  (msg0),
        .core_start    (cstart),
        .core_done     (core_done),
        .core_invalid  (core_invalid)
    );

    ecdsa_avalon_slave #(.TIMEOUT_CYCLES(32'd16)) dut_to (
        .clk           (clk),
        .reset         (reset),
        .avl           (bus1),
        .core_priv_key (key1),
        .core_message  (msg1),
        .core_start    (cstart_to),
        .core_done     (1'b0),
        .core_invalid  (1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] b);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; be = 4'h0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] r0,
                            output logic [31:0] r1);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1;
        r0 = bus0.avl_readdata;
        r1 = bus1.avl_readdata;
        cs = 1'b0; rd = 1'b0;
    endtask

    initial begin
        logic [31:0] r0, r1, exp;
        int hi;

        // Reset and full register map read-back
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("reset_start", {31'b0, cstart}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            bus_read(4'(i), r0, r1);
            exp = (i == 14) ? 32'hEC25_6001 : 32'h0;
            chk($sformatf("reset_word%0d", i), r0, exp);
        end

        // Byte-enable write
        bus_write(4'd3, 32'hDEAD_BEEF, 4'b0101);
        bus_read(4'd3, r0, r1);
        chk("be_word3", r0, 32'h00AD_00EF);
        chk("be_key", key0[127:96], 32'h00AD_00EF);
        bus_write(4'd8, 32'hA5A5_0008, 4'hF);
        chk("msg_word8", msg0[31:0], 32'hA5A5_0008);

        // Run that completes after 50 cycles; timeout instance aborts at 16
        model_en = 1'b1; done_after = 50; core_invalid = 1'b0;
        bus_write(4'd11, 32'h1, 4'h1);
        hi = 0;
        for (int i = 0; i < 200; i++) begin
            if (cstart) hi++;
            else break;
            @(negedge clk);
        end
        chk("start_len", 32'(hi), 32'd50);
        bus_read(4'd12, r0, r1);
        chk("status_ok", r0, 32'h1);
        chk("status_to", r1, 32'h9);
        bus_read(4'd13, r0, r1);
        chk("cycles_ok", r0, 32'd50);
        chk("cycles_to", r1, 32'd16);

        // Second run, invalid signature, operand write while busy
        done_after = 20; core_invalid = 1'b1;
        bus_write(4'd11, 32'h1, 4'h1);
        bus_write(4'd8, 32'h1234_5678, 4'hF);
        bus_read(4'd12, r0, r1);
        chk("status_busy", r0, 32'h4);
        chk("status_busy_to", r1, 32'h4);
        for (int i = 0; i < 200; i++) begin
            if (!cstart) break;
            @(negedge clk);
        end
        chk("run2_end", {31'b0, cstart}, 32'h0);
        bus_read(4'd8, r0, r1);
        chk("locked_word8", r0, 32'hA5A5_0008);
        chk("locked_msg", msg0[31:0], 32'hA5A5_0008);
        bus_read(4'd12, r0, r1);
        chk("status_inv", r0, 32'h3);
        bus_read(4'd13, r0, r1);
        chk("cycles_inv", r0, 32'd20);

        // Start+clear together: clear wins
        bus_write(4'd11, 32'h3, 4'h1);
        chk("clr_start", {31'b0, cstart}, 32'h0);
        bus_read(4'd12, r0, r1);
        chk("status_clr", r0, 32'h0);
        chk("status_clr_to", r1, 32'h0);
        bus_read(4'd13, r0, r1);
        chk("cycles_hold", r0, 32'd20);

        // Start without byte lane 0 and ID write are ignored
        bus_write(4'd11, 32'h1, 4'b1110);
        chk("be0_start", {31'b0, cstart}, 32'h0);
        bus_write(4'd14, 32'h0, 4'hF);
        bus_read(4'd14, r0, r1);
        chk("id_ro", r0, 32'hEC25_6001);

        // Reset in the middle of a run
        model_en = 1'b0;
        bus_write(4'd11, 32'h1, 4'h1);
        repeat (5) @(negedge clk);
        chk("mid_run", {31'b0, cstart}, 32'h1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst_start", {31'b0, cstart}, 32'h0);
        chk("rst_key", {31'b0, key0 != '0}, 32'h0);
        bus_read(4'd8, r0, r1);
        chk("rst_word8", r0, 32'h0);
        bus_read(4'd13, r0, r1);
        chk("rst_cycles", r0, 32'h0);
        done_force = 1'b1;
        @(negedge clk);
        done_force = 1'b0;
        bus_read(4'd12, r0, r1);
        chk("stray_done", r0, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ecdsa_avalon_slave.md
Name: ecdsa_avalon_slave

Overview:
- Avalon-MM slave front-end for the ECDSA sign/verify core.
- Lets the NIOS host load a 256-bit private key and a 96-bit message through 32-bit word writes, then issue a start command.
- Hands the operands to the core and waits for its done/invalid indications.
- Exposes status, the last run's cycle count and a timeout flag through a read-back register file.
- Implements the host-facing (initiator) end of the core's load/start/done interface.

Parameters:
- TIMEOUT_CYCLES, 32'h0FFF_FFFF, RUN cycles allowed before the run is aborted with the timeout flag set.
- CORE_ID, 32'hEC25_6001, constant returned by the ID register.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset; asserted when 0 at a rising clk edge.
- avl_chipselect  in  1  slave select.
- avl_read  in  1  read strobe; qualified by chipselect.
- avl_write  in  1  write strobe; qualified by chipselect.
- avl_address  in  4  word address.
- avl_byteenable  in  4  per-byte write enable.
- avl_writedata  in  32  write data.
- avl_readdata  out  32  read data; combinational, zero wait states.
- core_priv_key  out  256  key operand, words 0..7, word 0 = bits [31:0].
- core_message  out  96  message operand, words 8..10, word 8 = bits [31:0].
- core_start  out  1  held high for the whole RUN state.
- core_done  in  1  core completion, level.
- core_invalid  in  1  core signature-invalid flag; sampled with core_done.

Behaviour:
- Register map by word:
  - 0-7: KEY.
  - 8-10: MSG.
  - 11: CTRL. W: bit0 start, bit1 clear. R: 0.
  - 12: STATUS. R: bit0 done, bit1 invalid, bit2 busy, bit3 timeout.
  - 13: CYCLES. R: RUN-cycle count of the last run.
  - 14: ID. R: CORE_ID.
  - 15: reserved. R: 0; writes ignored.
- Reset (reset=0 at a clock edge):
  - KEY and MSG words cleared to 0; cycle count cleared to 0.
  - STATUS cleared to 0; core_start=0; state=IDLE.
  - Reset mid-RUN aborts the run immediately: core_start=0 on the next cycle.
- Writes:
  - Accepted when chipselect & write. Byte lanes are updated only where byteenable is set.
  - Writes to KEY/MSG are ignored while busy, so operands stay stable during RUN.
  - Writes to STATUS, CYCLES and ID are ignored.
- Reads: avl_readdata = mapped value when chipselect & read, else 32'h0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on a CTRL write with bit0=1 and byteenable[0]=1. On entry: counter cleared to 0; done, invalid and timeout cleared.
  - RUN:
    - core_start=1, busy=1.
    - Counter increments by 1 every cycle and saturates at 32'hFFFF_FFFF.
    - On core_done=1: latch invalid<=core_invalid, done<=1, go to DONE.
    - Timeout: if the count reaches TIMEOUT_CYCLES with core_done still 0, set timeout=1, done=1, invalid=0, go to DONE.
    - core_done and timeout in the same cycle: core_done wins.
    - Start writes in RUN are ignored.
  - DONE:
    - core_start=0, busy=0; status held until acted on.
    - Start write -> RUN, same entry actions as from IDLE.
    - Clear write (bit1=1) -> IDLE, status cleared.
    - Start and clear both set in one write: clear takes priority, go to IDLE.
  - IDLE with clear written: stays IDLE, status cleared.
- Transition timing: FSM transitions take effect at the clock edge after the qualifying write or input. core_start rises one cycle after the start write.
- CYCLES read value: counter value at DONE entry; holds until the next start.
- core_done arriving outside RUN is ignored.
- Width rules: counter is 32 bits. A TIMEOUT_CYCLES value of 0 is illegal; behaviour is then a timeout after 1 cycle.

Decomposition:
- Shared package elliptic_curve_structs gains:
  - address localparams: REG_KEY0=0, REG_MSG0=8, REG_CTRL=11, REG_STATUS=12, REG_CYCLES=13, REG_ID=14;
  - the enum type slave_state_t {IDLE, RUN, DONE};
  - STATUS bit-index localparams.
- One natural sub-module: avl_word_reg, a 32-bit register with byte-enable write and a lock input. It is instantiated 11 times for KEY/MSG.
- FSM, counter and read mux stay in the top.

Test Plan:
- Reset then read all 16 words -> KEY/MSG/STATUS/CYCLES read 0, word 14 reads 32'hEC25_6001, word 15 reads 0.
- Write word 3 = 32'hDEADBEEF with byteenable 4'b0101, read back -> 32'h00AD00EF; core_priv_key[127:96] equals 32'h00AD00EF.
- Start; model asserts core_done with core_invalid=0 after 50 RUN cycles -> core_start high exactly 50 cycles; STATUS=4'b0001; CYCLES=50.
- During RUN write word 8 = 32'h12345678 -> ignored, MSG unchanged. Model returns core_invalid=1 -> STATUS=4'b0011.
- TIMEOUT_CYCLES=16 with the model never asserting done -> STATUS=4'b1001 after 16 RUN cycles; CYCLES=16. Then CTRL=2'b11 -> state IDLE, STATUS=0.
- Pull reset to 0 for 1 cycle mid-RUN -> core_start=0 next cycle, all registers 0; a later core_done pulse leaves STATUS=0.
